// File: rtl/shifter_arbiter.sv
// -----------------------------------------------------------------------------
// shifter_arbiter
//
// Shares one external 16-bit combinational rotate-left shifter between two
// requesters. One operation is in flight at a time.
//   IDLE  : arbitrate and accept one request.
//   ISSUE : registered operands drive the shifter for one full cycle.
//   RESP  : the captured result is held until the consumer takes it.
// Completed responses are counted per requester. The counters wrap.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid/payload stable until ready. ready never
// depends on the state of the other side's ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqK_valid/data/amt      request from requester K (K = 0, 1)
//   reqK_ready               grant to requester K (IDLE only)
//   shf_i, shf_amt           operand and amount driven to the shifter
//   shf_o                    shifter result (combinational in shf_i/shf_amt)
//   rsp_valid/data/id        registered result and its owner
//   rsp_ready                consumer accepts the response
//   cnt0, cnt1               completed responses per requester
//   dbg_state                current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
// -----------------------------------------------------------------------------
module shifter_arbiter #(
    parameter int W  = 16,
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    input  logic [AW-1:0] req0_amt,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    input  logic [AW-1:0] req1_amt,
    output logic          req1_ready,
    output logic [W-1:0]  shf_i,
    output logic [AW-1:0] shf_amt,
    input  logic [W-1:0]  shf_o,
    output logic          rsp_valid,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_id,
    input  logic          rsp_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last;
    logic [W-1:0]  op_data;
    logic [AW-1:0] op_amt;
    logic          op_id;

    logic          grant0, grant1;
    logic          accept;
    logic          rsp_take;

    // Round robin: on a tie the requester that was not served last wins.
    // last resets to 1 so requester 0 wins the first tie.
    assign grant0 = req0_valid & (~req1_valid | last);
    assign grant1 = req1_valid & (~req0_valid | ~last);

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;

    assign accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign rsp_take = (state == RESP) & rsp_ready;

    assign shf_i     = op_data;
    assign shf_amt   = op_amt;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers: only written on an accept edge, so the shifter
    // inputs stay frozen through ISSUE and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_data <= '0;
            op_amt  <= '0;
            op_id   <= 1'b0;
            last    <= 1'b1;
        end else if (accept) begin
            op_data <= grant1 ? req1_data : req0_data;
            op_amt  <= grant1 ? req1_amt  : req0_amt;
            op_id   <= grant1;
            last    <= grant1;
        end
    end

    // Response register: data/id keep their values after the response is
    // taken; only rsp_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else if (state == ISSUE) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shf_o;
            rsp_id    <= op_id;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_take) begin
            if (rsp_id) cnt1 <= cnt1 + 1'b1;
            else        cnt0 <= cnt0 + 1'b1;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for shifter_arbiter. Provides a rotate-left shifter model on the
// shf_* ports, applies a table of single operations with hand-computed
// results, then hand-written sequences for fairness, backpressure, reset
// during an operation and counter wrap.
// -----------------------------------------------------------------------------
module tb_shifter_arbiter;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int CW = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]  req0_data = '0, req1_data = '0;
    logic [AW-1:0] req0_amt = '0, req1_amt = '0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  shf_i, shf_o;
    logic [AW-1:0] shf_amt;
    logic          rsp_valid, rsp_id;
    logic [W-1:0]  rsp_data;
    logic          rsp_ready = 1'b0;
    logic [CW-1:0] cnt0, cnt1;
    logic [1:0]    dbg_state;

    // External shifter: rotate left.
    logic [2*W-1:0] shf_dbl;
    assign shf_dbl = {shf_i, shf_i} << shf_amt;
    assign shf_o   = shf_dbl[2*W-1:W];

    shifter_arbiter #(.W(W), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt),
        .req1_ready(req1_ready),
        .shf_i(shf_i), .shf_amt(shf_amt), .shf_o(shf_o),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready),
        .cnt0(cnt0), .cnt1(cnt1), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_cnt0 = '0, exp_cnt1 = '0;
    logic [W:0]    exp_q[$];   // {id, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counts();
        chk("cnt0", 32'(cnt0), 32'(exp_cnt0));
        chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
    endtask

    // ---------------- driver ----------------
    // Called at a negedge while the DUT is in IDLE. Runs one operation to
    // completion, holding rsp_ready low for bp cycles in RESP.
    task automatic run_op(input logic id, input logic [W-1:0] data,
                          input logic [AW-1:0] amt, input logic [W-1:0] exp,
                          input int bp);
        bit got;
        logic [W-1:0] held_data;
        logic         held_id;
        if (id) begin
            req1_valid = 1'b1; req1_data = data; req1_amt = amt;
        end else begin
            req0_valid = 1'b1; req0_data = data; req0_amt = amt;
        end
        rsp_ready = (bp == 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        chk("grant", 32'(got), 32'd1);
        if (!got) begin
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
            return;
        end
        chk("other_ready_low", 32'(id ? req0_ready : req1_ready), 32'd0);
        @(negedge clk);
        // ISSUE: operands on the shifter, no response yet, readies low.
        chk("state_issue", 32'(dbg_state), 32'(S_ISSUE));
        chk("shf_i", 32'(shf_i), 32'(data));
        chk("shf_amt", 32'(shf_amt), 32'(amt));
        chk("rsp_valid_issue", 32'(rsp_valid), 32'd0);
        chk("readies_issue", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        // RESP
        chk("state_resp", 32'(dbg_state), 32'(S_RESP));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("readies_resp", 32'({req0_ready, req1_ready}), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        held_data = rsp_data; held_id = rsp_id;
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'(held_data));
            chk("bp_id", 32'(rsp_id), 32'(held_id));
            chk("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
            chk_counts();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        if (id) exp_cnt1++; else exp_cnt0++;
        chk("state_idle", 32'(dbg_state), 32'(S_IDLE));
        chk("rsp_valid_taken", 32'(rsp_valid), 32'd0);
        chk("rsp_data_kept", 32'(rsp_data), 32'(exp));
        chk_counts();
        rsp_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          id;
        logic [W-1:0]  data;
        logic [AW-1:0] amt;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[20];
    logic [W-1:0] sweep_exp[16];

    initial begin
        bit got;
        logic gid;
        logic [W:0] e;

        // Table: single op, a few mixed ops, then the req1 sweep (ends on id 1).
        vecs[0] = '{1'b0, 16'h8000, 4'd1, 16'h0001};
        vecs[1] = '{1'b0, 16'h1234, 4'd4, 16'h2341};
        vecs[2] = '{1'b1, 16'hFFFF, 4'd7, 16'hFFFF};
        vecs[3] = '{1'b0, 16'h0000, 4'd9, 16'h0000};
        sweep_exp = '{16'h8040, 16'h0081, 16'h0102, 16'h0204,
                      16'h0408, 16'h0810, 16'h1020, 16'h2040,
                      16'h4080, 16'h8100, 16'h0201, 16'h0402,
                      16'h0804, 16'h1008, 16'h2010, 16'h4020};
        for (int k = 0; k < 16; k++)
            vecs[4+k] = '{1'b1, 16'h8040, 4'(k), sweep_exp[k]};

        // Reset then idle.
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(dbg_state), 32'(S_IDLE));
        chk("idle_readies", 32'({req0_ready, req1_ready}), 32'd0);
        chk("idle_shf_i", 32'(shf_i), 32'd0);
        chk("idle_shf_amt", 32'(shf_amt), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rsp_data", 32'(rsp_data), 32'd0);
        chk("idle_rsp_id", 32'(rsp_id), 32'd0);
        chk_counts();

        for (int v = 0; v < 20; v++)
            run_op(vecs[v].id, vecs[v].data, vecs[v].amt, vecs[v].exp, 0);
        chk("cnt1_after_sweep", 32'(cnt1), 32'd17);

        // Fairness: both valid throughout, grants must go 0,1,0,1.
        req0_valid = 1'b1; req0_data = 16'h0001; req0_amt = 4'd2;
        req1_valid = 1'b1; req1_data = 16'h0001; req1_amt = 4'd3;
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                #1;
                if (req0_ready || req1_ready) got = 1'b1;
                else @(negedge clk);
            end
            chk("fair_grant_seen", 32'(got), 32'd1);
            chk("fair_one_ready", 32'({req0_ready, req1_ready} == 2'b11), 32'd0);
            gid = req1_ready;
            chk("fair_order", 32'(gid), 32'(g % 2));
            exp_q.push_back((g % 2) ? {1'b1, 16'h0008} : {1'b0, 16'h0004});
            @(negedge clk);
            @(negedge clk);
            chk("fair_rsp_valid", 32'(rsp_valid), 32'd1);
            e = exp_q.pop_front();
            chk("fair_rsp", 32'({rsp_id, rsp_data}), 32'(e));
            if (e[W]) exp_cnt1++; else exp_cnt0++;
            @(negedge clk);
            chk_counts();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);

        // Backpressure.
        run_op(1'b0, 16'h00F0, 4'd8, 16'hF000, 5);

        // Reset during ISSUE.
        req0_valid = 1'b1; req0_data = 16'hFFFF; req0_amt = 4'd3;
        #1;
        chk("midrst_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        chk("midrst_issue", 32'(dbg_state), 32'(S_ISSUE));
        rst = 1'b1;
        req0_valid = 1'b0;
        #1;
        exp_cnt0 = '0; exp_cnt1 = '0;
        chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("midrst_shf_i", 32'(shf_i), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_counts();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("midrst_cnt0", 32'(cnt0), 32'd0);
        end
        run_op(1'b0, 16'h8000, 4'd1, 16'h0001, 0);

        // Counter wrap: 255 more req0 ops bring cnt0 to 256 -> 0.
        for (int k = 0; k < 255; k++)
            run_op(1'b0, 16'h0003, 4'd15, 16'h8001, 0);
        chk("cnt0_wrap", 32'(cnt0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
